calc_result_display: RTL and testbench
======================================

// Module: calc_result_display
// PURPOSE
//  Reader/display end of the calculator result path: consumes the 7-bit result C and the equal strobe.
//  Converts C to BCD with a sequential shift-add-3 (double-dabble) engine, holds the last converted value.
//  Drives a time-multiplexed 7-segment display. Sits between Scientific_calculator and board pins.
// PARAMETERS
//  RES_W        7   width of binary result input C
//  DIGITS       3   number of BCD digits / display positions (must cover 2**RES_W-1)
//  REFRESH_DIV  4   clk cycles each digit stays selected before the scan advances (>=1)
// PORTS
//  clk         in   1           single clock, all logic on rising edge
//  reset       in   1           asynchronous, active-low; 0 clears all state immediately
//  equal       in   1           result-valid level from calculator; rising edge requests a conversion
//  C           in   RES_W       binary result, sampled only on an accepted request
//  busy        out  1           1 while a conversion is in progress
//  done        out  1           one-cycle pulse when new BCD value is loaded
//  bcd         out  4*DIGITS    held BCD value, digit 0 (units) in bits [3:0]
//  seg         out  7           active-high segments, order {g,f,e,d,c,b,a}
//  an          out  DIGITS      one-hot active-high digit select, an[0] = units
// BEHAVIOUR
//  Reset values: busy=0, done=0, bcd=0, seg=pattern for "0" (7'b0111111), an=1 (digit 0), FSM=IDLE,
//   scan counters=0, equal edge register=0 (equal already high at reset release counts as a rising edge).
//  Request: equal_q <= equal each cycle; request = equal & ~equal_q. Level-held equal does not retrigger.
//  FSM IDLE: on request capture C into shift reg, clear BCD scratch, load bit counter RES_W, -> CONVERT.
//  FSM CONVERT: per cycle add 3 to every scratch nibble >=5, then shift {scratch,shreg} left 1;
//   decrement counter; after RES_W shifts -> LOAD. busy=1 throughout CONVERT and LOAD.
//  FSM LOAD: bcd <= scratch, done=1 for this cycle, -> IDLE.
//  Latency: request cycle N; done high in cycle N+RES_W+1; bcd valid from cycle N+RES_W+2 (9 for RES_W=7).
//  Requests while busy are dropped (no queue); C changes while busy do not affect the conversion.
//  Request in the LOAD cycle is dropped; one arriving in the first IDLE cycle after is accepted.
//  bcd and display hold the previous value until LOAD; never show partial results.
//  Scan: divider counts 0..REFRESH_DIV-1; on wrap digit index advances 0..DIGITS-1 then wraps to 0.
//   an = one-hot(digit index); seg = seg7(bcd nibble at index); registered, updates one cycle after index.
//  Scan runs continuously, independent of FSM state.
//  Reset asserted mid-conversion: abort, return to IDLE, outputs to reset values; no done pulse.
//  Nibble values >9 cannot occur; seg7 of 10..15 decodes to all-off (7'b0).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: a digit above units whose nibble and all higher nibbles are zero
//   drives seg=0 (blank); units digit always shown. Value 5 shows "  5", 0 shows "  0".
//  Not defined: all digits always shown with leading zeros ("005"). bcd output unaffected either way.
// STRUCTURE
//  Package calc_disp_pkg: state enum (IDLE, CONVERT, LOAD), seg7 pattern constants for 0..9 and BLANK,
//   function seg7_enc(nibble) -> [6:0].
//  Sub-module calc_bin2bcd: sequential double-dabble engine (start, bin in, busy, done, bcd out),
//   parameterised by RES_W/DIGITS; top holds edge detect, output register and scan mux.
// TESTING
//  1 Reset low then high, equal=0 -> busy=0, done=0, bcd=0, an=001, seg=7'b0111111 scanning units.
//  2 C=127, equal 0->1 -> busy next cycle, done pulse 8 cycles after edge, bcd=12'h127; scan shows 7,2,1.
//  3 C=0 then C=5 conversions -> bcd=000/005; with LEADING_ZERO_BLANK_EN an[2:1] digits seg=0, else "0".
//  4 equal held 1 for 30 cycles after one conversion, C changed to 3 -> no second done, bcd unchanged.
//  5 second equal edge at cycle 3 of conversion (C=42 then C=99) -> ignored, bcd=12'h042.
//  6 reset low at cycle 4 of conversion of C=100 -> busy=0, bcd=0 immediately; no done after release.
//  7 REFRESH_DIV=4: an sequence 001,010,100,001 each held exactly 4 cycles across wrap.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - shared types, segment patterns and decoder for the result display
// Contents:
//   state_t      conversion FSM states (IDLE, CONVERT, LOAD)
//   SEG_0..SEG_9 active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    all segments off
//   seg7_enc     BCD nibble -> segment pattern; 10..15 decode to blank
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7_enc(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg7_enc = SEG_0;
      4'd1:    seg7_enc = SEG_1;
      4'd2:    seg7_enc = SEG_2;
      4'd3:    seg7_enc = SEG_3;
      4'd4:    seg7_enc = SEG_4;
      4'd5:    seg7_enc = SEG_5;
      4'd6:    seg7_enc = SEG_6;
      4'd7:    seg7_enc = SEG_7;
      4'd8:    seg7_enc = SEG_8;
      4'd9:    seg7_enc = SEG_9;
      default: seg7_enc = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// rtl/calc_result_display_if.sv - result/display bundle between calculator and display block
// Signals:
//   equal  result-valid level from the calculator (rising edge requests conversion)
//   C      binary result
//   busy   conversion in progress
//   done   one-cycle pulse when a new BCD value is loaded
//   bcd    held BCD value, units in [3:0]
//   seg    active-high segments {g,f,e,d,c,b,a}
//   an     one-hot active-high digit select, an[0] = units
// Modports: master = calculator/board side, slave = calc_result_display.
interface calc_result_display_if #(
  parameter int RES_W  = 7,
  parameter int DIGITS = 3
);
  logic                  equal;
  logic [RES_W-1:0]      C;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (output equal, C, input busy, done, bcd, seg, an);
  modport slave  (input equal, C, output busy, done, bcd, seg, an);
endinterface

// File: rtl/calc_bin2bcd.sv
// rtl/calc_bin2bcd.sv - sequential shift-add-3 (double-dabble) binary to BCD engine
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   start       request; honoured only in IDLE
//   bin         binary input, captured on an accepted start
//   busy        high through CONVERT and LOAD
//   done        high for the single LOAD cycle
//   bcd         scratch register; valid while done is high
module calc_bin2bcd
  import calc_disp_pkg::*;
#(
  parameter int RES_W  = 7,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RES_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(RES_W + 1);

  state_t              state;
  logic [RES_W-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(RES_W);
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= {adj[4*DIGITS-2:0], shreg[RES_W-1]};
          shreg   <= {shreg[RES_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bcd = scratch;

endmodule

// File: rtl/calc_result_display.sv
// rtl/calc_result_display.sv - result-to-BCD converter with multiplexed 7-segment display
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   disp   calc_result_display_if.slave: equal/C in; busy/done/bcd/seg/an out
// Parameters: RES_W (result width), DIGITS (display positions), REFRESH_DIV (cycles per digit).
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading-zero digits above units.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int RES_W       = 7,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  calc_result_display_if.slave disp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                equal_q;
  logic                request;
  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [4*DIGITS-1:0] bcd_q;

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   an_nxt;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          nib;
  logic [6:0]          seg_nxt;

  // equal_q clears on reset, so equal already high at release is an edge.
  assign request = disp.equal & ~equal_q;

  calc_bin2bcd #(.RES_W(RES_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (request),
    .bin   (disp.C),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Held result only moves on done, so partial scratch never reaches the display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      equal_q <= 1'b0;
      bcd_q   <= '0;
    end else begin
      equal_q <= disp.equal;
      if (conv_done) bcd_q <= conv_bcd;
    end
  end

  always_comb begin
    an_nxt = '0;
    blank  = '0;
    nib    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      an_nxt[i] = (idx == IDX_W'(i));
      if (an_nxt[i]) nib = bcd_q[4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin : g_lz
      logic zero_run;
      zero_run = 1'b1;
      // Walk down from the top digit; units (i=0) is never blanked.
      for (int i = DIGITS - 1; i > 0; i--) begin
        zero_run = zero_run & (bcd_q[4*i +: 4] == 4'd0);
        blank[i] = zero_run;
      end
    end
`endif
    seg_nxt = (|(blank & an_nxt)) ? SEG_BLANK : seg7_enc(nib);
  end

  // Free-running scan; an/seg are registered so they trail idx by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      idx   <= '0;
      an_q  <= DIGITS'(1);
      seg_q <= SEG_0;
    end else begin
      if (div == DIV_W'(REFRESH_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign disp.busy = conv_busy;
  assign disp.done = conv_done;
  assign disp.bcd  = bcd_q;
  assign disp.an   = an_q;
  assign disp.seg  = seg_q;

endmodule

// File: tb/tb_calc_result_display.sv
// tb/tb_calc_result_display.sv - scoreboard bench for calc_result_display
module tb_calc_result_display;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b0000111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SLZ = 7'b0000000;
`else
  localparam logic [6:0] SLZ = 7'b0111111;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   pend = 1'b0;
  logic [11:0] exp_q[$];

  calc_result_display_if #(.RES_W(7), .DIGITS(3)) dif ();

  calc_result_display #(.RES_W(7), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: bcd is checked the cycle after each done pulse against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done bcd=%0h", dif.bcd);
        end else begin
          chk("scoreboard_bcd", 32'(dif.bcd), 32'(exp_q.pop_front()));
        end
      end
      pend = dif.done;
      if (dif.done) done_cnt++;
    end
  end

  task automatic convert(input logic [6:0] c, input logic [11:0] exp, input bit hold);
    int k;
    k = 0;
    dif.C = c;
    dif.equal = 1'b1;
    exp_q.push_back(exp);
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step();
      if (i == 1) chk("busy_after_edge", 32'(dif.busy), 32'd1);
      if (dif.done) k = i;
    end
    chk("done_latency", k, 8);
    step();
    step();
    if (!hold) dif.equal = 1'b0;
    step();
  endtask

  task automatic wait_digit(input string name, input int idx, input logic [6:0] exp_seg);
    logic [2:0] want;
    want = 3'(1 << idx);
    for (int i = 0; i < 20 && dif.an !== want; i++) step();
    chk({name, "_an"}, 32'(dif.an), 32'(want));
    chk({name, "_seg"}, 32'(dif.seg), 32'(exp_seg));
  endtask

  initial begin
    int base;
    logic [2:0] prev_an;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] scan_seg[3];
    scan_seg[0] = S7;
    scan_seg[1] = S2;
    scan_seg[2] = S1;

    dif.equal = 1'b0;
    dif.C = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    // 1: reset state
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_bcd", 32'(dif.bcd), 32'h000);
    chk("rst_an", 32'(dif.an), 32'b001);
    chk("rst_seg", 32'(dif.seg), 32'(S0));

    // 2: 127 and scan contents
    convert(7'd127, 12'h127, 1'b0);
    chk("bcd_127", 32'(dif.bcd), 32'h127);
    wait_digit("d127_0", 0, S7);
    wait_digit("d127_1", 1, S2);
    wait_digit("d127_2", 2, S1);

    // 7: scan timing across wrap, each digit held exactly 4 cycles
    prev_an = dif.an;
    for (int i = 0; i < 20 && !(dif.an === 3'b001 && prev_an !== 3'b001); i++) begin
      prev_an = dif.an;
      step();
    end
    for (int k = 0; k < 16; k++) begin
      exp_an = 3'(1 << ((k / 4) % 3));
      exp_seg = scan_seg[(k / 4) % 3];
      chk("scan_an", 32'(dif.an), 32'(exp_an));
      chk("scan_seg", 32'(dif.seg), 32'(exp_seg));
      step();
    end

    // 3: zero and single-digit values, leading-digit display
    convert(7'd0, 12'h000, 1'b0);
    chk("bcd_0", 32'(dif.bcd), 32'h000);
    wait_digit("d0_0", 0, S0);
    wait_digit("d0_2", 2, SLZ);
    convert(7'd5, 12'h005, 1'b0);
    chk("bcd_5", 32'(dif.bcd), 32'h005);
    wait_digit("d5_0", 0, S5);
    wait_digit("d5_1", 1, SLZ);
    wait_digit("d5_2", 2, SLZ);

    // 4: equal held high does not retrigger
    convert(7'd64, 12'h064, 1'b1);
    base = done_cnt;
    dif.C = 7'd3;
    repeat (30) step();
    chk("held_no_done", done_cnt, base);
    chk("held_bcd", 32'(dif.bcd), 32'h064);
    dif.equal = 1'b0;
    step();

    // 5: second edge during conversion is dropped
    base = done_cnt;
    dif.C = 7'd42;
    dif.equal = 1'b1;
    exp_q.push_back(12'h042);
    step();
    step();
    dif.equal = 1'b0;
    step();
    dif.C = 7'd99;
    dif.equal = 1'b1;
    repeat (15) step();
    chk("busy_edge_one_done", done_cnt, base + 1);
    chk("busy_edge_bcd", 32'(dif.bcd), 32'h042);
    dif.equal = 1'b0;
    step();

    // 6: reset mid-conversion
    base = done_cnt;
    dif.C = 7'd100;
    dif.equal = 1'b1;
    repeat (4) step();
    chk("midrst_busy_pre", 32'(dif.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(dif.busy), 32'd0);
    chk("midrst_bcd", 32'(dif.bcd), 32'h000);
    chk("midrst_an", 32'(dif.an), 32'b001);
    chk("midrst_seg", 32'(dif.seg), 32'(S0));
    dif.equal = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("midrst_no_done", done_cnt, base);
    chk("midrst_bcd_after", 32'(dif.bcd), 32'h000);
    chk("midrst_idle", 32'(dif.busy), 32'd0);

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
